// File: rtl/gbsha_fir_host_if.sv
// Stream handshake bundle for gbsha_fir_host: sample input (s_*) and result output (m_*).
// slave is the host block side, master is the producer/consumer side.
interface gbsha_fir_host_if #(
    parameter int BW_in  = 6,
    parameter int BW_out = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [BW_in-1:0]  s_data;
    logic              m_valid;
    logic              m_ready;
    logic [BW_out-1:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/gbsha_fir_host.sv
// Host-side pin driver for the gbsha_top single-tap FIR: generates FIR clock/reset,
// loads the coefficient, streams samples and buffers the realigned results.
module gbsha_fir_host #(
    parameter int BW_in      = 6,
    parameter int BW_out     = 8,
    parameter int RST_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BW_in-1:0] cfg_coeff,
    output logic             busy,
    gbsha_fir_host_if.slave  bus,
    output logic [7:0]       fir_io_in,
    input  logic [7:0]       fir_io_out
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_COEF = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam logic [NW:0] DEPTH_C = (NW+1)'(FIFO_DEPTH);

    logic [1:0]        state;
    logic              ph;
    logic [BW_in-1:0]  coeff;
    logic [CW-1:0]     rst_cnt;
    logic              fir_rst;
    logic [BW_in-1:0]  x_in;
    logic              inflight;

    logic [BW_out-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [NW-1:0]     count;
    logic [NW-1:0]     count_next;
    logic [NW:0]       credit_used;
    logic              m_valid_q;

    logic fall;
    logic accept;
    logic push;
    logic pop;

    assign fall        = ph;
    assign credit_used = {1'b0, count} + {{NW{1'b0}}, inflight};
    // Credit ignores a same-cycle pop so the ready path stays off m_ready.
    assign bus.s_ready = (state == S_RUN) && ph && (credit_used < DEPTH_C);
    assign accept      = bus.s_valid && bus.s_ready;
    assign push        = fall && inflight;
    assign pop         = m_valid_q && bus.m_ready;
    assign count_next  = count + NW'(push) - NW'(pop);

    assign busy        = (state != S_IDLE);
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = mem[rd_ptr];

    always_comb begin
        fir_io_in              = '0;
        fir_io_in[0]           = ph;
        fir_io_in[1]           = fir_rst;
        fir_io_in[BW_in+1:2]   = x_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ph       <= 1'b0;
            coeff    <= '0;
            rst_cnt  <= '0;
            fir_rst  <= 1'b1;
            x_in     <= '0;
            inflight <= 1'b0;
        end else begin
            ph <= ~ph;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        fir_rst <= 1'b1;
                        x_in    <= '0;
                    end
                    if (start) begin
                        coeff   <= cfg_coeff;
                        rst_cnt <= '0;
                        state   <= S_RST;
                    end
                end
                S_RST: begin
                    // Count FIR rises (ph 0->1); leave on the first fall edge after the last one.
                    if (!ph && rst_cnt != CW'(RST_CYCLES)) begin
                        rst_cnt <= rst_cnt + CW'(1);
                    end else if (fall && rst_cnt == CW'(RST_CYCLES)) begin
                        fir_rst <= 1'b0;
                        x_in    <= coeff;
                        state   <= S_COEF;
                    end
                end
                S_COEF: begin
                    if (fall) begin
                        x_in  <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (fall) begin
                        x_in     <= accept ? bus.s_data : '0;
                        inflight <= accept;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fir_io_out[BW_out-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_next;
            m_valid_q <= (count_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push && !pop) begin
            assert (count != NW'(FIFO_DEPTH));
        end
    end
endmodule

// File: tb/tb_gbsha_fir_host.sv
// Directed bench for gbsha_fir_host with a behavioural single-tap FIR on the pins.
module tb_gbsha_fir_host;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] cfg_coeff = '0;
    logic       busy;
    logic [7:0] fir_io_in;
    logic [7:0] fir_io_out;

    gbsha_fir_host_if #(.BW_in(6), .BW_out(8)) bus ();

    gbsha_fir_host #(
        .BW_in(6),
        .BW_out(8),
        .RST_CYCLES(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .cfg_coeff(cfg_coeff),
        .busy(busy),
        .bus(bus),
        .fir_io_in(fir_io_in),
        .fir_io_out(fir_io_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural FIR: first rise after reset loads the coefficient, later rises multiply.
    logic signed [5:0]  fir_coeff = '0;
    logic               fir_loaded = 1'b0;
    logic [7:0]         fir_out_q = '0;
    logic signed [11:0] fir_prod;
    logic [6:0]         rise_log [$];

    assign fir_io_out = fir_out_q;

    always @(posedge fir_io_in[0]) begin
        rise_log.push_back(fir_io_in[7:1]);
        if (fir_io_in[1]) begin
            fir_loaded <= 1'b0;
            fir_out_q  <= '0;
        end else if (!fir_loaded) begin
            fir_coeff  <= $signed(fir_io_in[7:2]);
            fir_loaded <= 1'b1;
        end else begin
            fir_prod = fir_coeff * $signed(fir_io_in[7:2]);
            fir_out_q <= fir_prod[7:0];
        end
    end

    typedef struct packed {
        logic       vld;
        logic [5:0] d;
    } drv_t;

    drv_t       drv_q [$];
    logic [7:0] exp_q [$];
    int  cyc = 0;
    int  n_acc = 0;
    int  n_rcv = 0;
    int  extra = 0;
    int  first_acc = -1;
    int  first_mv = -1;
    int  tog_err = 0;
    logic acc_pending = 1'b0;
    logic prev_ph = 1'b0;
    logic prev_ok = 1'b0;

    always @(posedge clk) cyc++;

    // Source: holds each sample until accepted; a gap entry idles s_valid for one clk.
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
    end

    always @(negedge clk) begin
        if (acc_pending) begin
            drv_q.delete(0);
            n_acc++;
            acc_pending = 1'b0;
        end else if (drv_q.size() != 0 && !drv_q[0].vld) begin
            drv_q.delete(0);
        end
        if (drv_q.size() != 0 && drv_q[0].vld) begin
            bus.s_valid = 1'b1;
            bus.s_data  = drv_q[0].d;
        end else begin
            bus.s_valid = 1'b0;
            bus.s_data  = '0;
        end
        if (reset_n && bus.s_valid && bus.s_ready) begin
            acc_pending = 1'b1;
            if (first_acc < 0) first_acc = cyc + 1;
        end
    end

    // Sink / scoreboard, plus FIR clock toggle monitor.
    always @(negedge clk) begin
        if (reset_n && bus.m_valid) begin
            if (first_mv < 0) first_mv = cyc;
            if (bus.m_ready) begin
                n_rcv++;
                if (exp_q.size() != 0) check("result", 32'(bus.m_data), 32'(exp_q.pop_front()));
                else extra++;
            end
        end
        if (reset_n && prev_ok && fir_io_in[0] == prev_ph) tog_err++;
        prev_ph = fir_io_in[0];
        prev_ok = reset_n;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        start   = 1'b0;
        reset_n = 1'b0;
        step(2);
        check("rst_fio", 32'(fir_io_in), 32'h02);
        check("rst_busy", 32'(busy), 0);
        check("rst_mvalid", 32'(bus.m_valid), 0);
        check("rst_sready", 32'(bus.s_ready), 0);
        exp_q.delete();
        n_acc = 0;
        n_rcv = 0;
        extra = 0;
        first_acc = -1;
        first_mv = -1;
        reset_n = 1'b1;
    endtask

    // Line the start pulse up with a fall edge so the rise log starts cleanly.
    task automatic do_start(input logic [5:0] c);
        int t;
        t = 0;
        while (fir_io_in[0] !== 1'b1 && t < 10) begin
            step(1);
            t++;
        end
        cfg_coeff = c;
        start = 1'b1;
        rise_log.delete();
        step(1);
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
    endtask

    task automatic send(input logic [5:0] d, input logic [7:0] e);
        drv_q.push_back({1'b1, d});
        exp_q.push_back(e);
    endtask

    task automatic gap();
        drv_q.push_back({1'b0, 6'd0});
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || drv_q.size() != 0) && t < budget) begin
            step(1);
            t++;
        end
        check(tag, 32'(exp_q.size() + drv_q.size()), 0);
        step(6);
        check("no_extra", 32'(extra), 0);
    endtask

    task automatic wait_fall_phase();
        int t;
        t = 0;
        while (fir_io_in[0] !== 1'b1 && t < 4) begin
            step(1);
            t++;
        end
    endtask

    logic [6:0] rl [5];

    initial begin
        // T1 / T2: coeff 3, back-to-back samples, pin sequence and latency.
        do_reset();
        bus.m_ready = 1'b1;
        do_start(6'd3);
        send(6'd5, 8'h0F);
        send(6'h3E, 8'hFA);
        send(6'd1, 8'h03);
        drain("t1_drain", 100);
        check("t1_count", 32'(n_rcv), 3);
        check("t1_latency", 32'(first_mv - first_acc), 2);
        for (int i = 0; i < 5; i++) rl[i] = (rise_log.size() > i) ? rise_log[i] : 7'h7F;
        check("t2_rise0_rst", 32'(rl[0]), 32'h01);
        check("t2_rise1_rst", 32'(rl[1]), 32'h01);
        check("t2_rise2_coef", 32'(rl[2]), 32'h06);
        check("t2_rise3_bubble", 32'(rl[3]), 32'h00);
        check("t2_rise4_sample", 32'(rl[4]), 32'h0A);

        // T3: back-pressure, only FIFO_DEPTH samples accepted while m_ready is low.
        do_reset();
        bus.m_ready = 1'b0;
        do_start(6'd5);
        for (int i = 1; i <= 6; i++) send(6'(i), 8'(5 * i));
        step(40);
        check("t3_accepted", 32'(n_acc), 4);
        wait_fall_phase();
        check("t3_fall_phase", 32'(fir_io_in[0]), 1);
        check("t3_sready_low", 32'(bus.s_ready), 0);
        check("t3_mvalid", 32'(bus.m_valid), 1);
        bus.m_ready = 1'b1;
        drain("t3_drain", 100);
        check("t3_acc_all", 32'(n_acc), 6);
        check("t3_rcv_all", 32'(n_rcv), 6);

        // T4: gaps in s_valid with coeff -1; bubbles produce no results.
        do_reset();
        bus.m_ready = 1'b1;
        do_start(6'h3F);
        send(6'd7, 8'hF9);
        gap();
        gap();
        send(6'd2, 8'hFE);
        gap();
        send(6'h3C, 8'h04);
        drain("t4_drain", 100);
        check("t4_count", 32'(n_rcv), 3);

        // T5: extreme operands wrap to the low 8 bits.
        do_reset();
        do_start(6'h20);
        send(6'h20, 8'h00);
        drain("t5a_drain", 100);
        do_reset();
        do_start(6'h1F);
        send(6'h20, 8'h20);
        drain("t5b_drain", 100);

        // T6: start in RUN ignored; reset mid-RUN drops buffered results.
        do_reset();
        bus.m_ready = 1'b0;
        do_start(6'd2);
        drv_q.push_back({1'b1, 6'd3});
        drv_q.push_back({1'b1, 6'd4});
        begin : wait_acc
            int t;
            t = 0;
            while (drv_q.size() != 0 && t < 60) begin
                step(1);
                t++;
            end
        end
        step(6);
        check("t6_accepted", 32'(n_acc), 2);
        check("t6_buffered", 32'(bus.m_valid), 1);
        cfg_coeff = 6'd9;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check("t6_start_ign_busy", 32'(busy), 1);
        check("t6_start_ign_rst", 32'(fir_io_in[1]), 0);
        reset_n = 1'b0;
        step(1);
        check("t6_mvalid", 32'(bus.m_valid), 0);
        check("t6_fio", 32'(fir_io_in), 32'h02);
        check("t6_busy", 32'(busy), 0);
        reset_n = 1'b1;
        step(4);
        check("t6_still_empty", 32'(bus.m_valid), 0);
        exp_q.delete();
        n_rcv = 0;
        extra = 0;
        bus.m_ready = 1'b1;
        do_start(6'd1);
        send(6'd7, 8'h07);
        drain("t6_after_drain", 100);
        check("t6_after_count", 32'(n_rcv), 1);

        check("fir_clk_toggle", 32'(tog_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
